// File: rtl/audio_interval_peak_stream_if.sv
// Stream and result bundle for audio_interval_peak_stream: run control,
// configuration, sample input and per-interval results.
interface audio_interval_peak_stream_if #(
    parameter int W      = 32,
    parameter int NUM_CH = 2,
    parameter int LEN_W  = 16,
    parameter int CNT_W  = 16
);
    logic                    start;
    logic                    stop;
    logic [LEN_W-1:0]        interval_len;
    logic [CNT_W-1:0]        num_intervals;
    logic                    in_valid;
    logic [NUM_CH*W-1:0]     in_data;
    logic                    busy;
    logic                    cfg_err;
    logic                    out_valid;
    logic [CNT_W-1:0]        out_index;
    logic [NUM_CH*W-1:0]     out_max;
    logic [NUM_CH*W-1:0]     out_min;
    logic [NUM_CH*(W+1)-1:0] out_p2p;
    logic                    done;

    modport master (
        output start, stop, interval_len, num_intervals, in_valid, in_data,
        input  busy, cfg_err, out_valid, out_index, out_max, out_min, out_p2p, done
    );

    modport slave (
        input  start, stop, interval_len, num_intervals, in_valid, in_data,
        output busy, cfg_err, out_valid, out_index, out_max, out_min, out_p2p, done
    );
endinterface

// File: rtl/audio_interval_peak_stream.sv
// Streaming per-channel interval max/min/peak-to-peak tracker for NUM_CH
// signed audio channels, with counted or continuous runs.
module audio_interval_peak_stream #(
    parameter int W      = 32,
    parameter int NUM_CH = 2,
    parameter int LEN_W  = 16,
    parameter int CNT_W  = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    audio_interval_peak_stream_if.slave   bus
);
    typedef enum logic {IDLE, RUN} state_e;

    state_e                   state_q, state_d;
    logic [LEN_W-1:0]         len_q, len_d, sample_cnt_q, sample_cnt_d;
    logic [CNT_W-1:0]         num_q, num_d, int_cnt_q, int_cnt_d, int_nxt;
    logic [NUM_CH-1:0][W-1:0] run_max_q, run_max_d, run_min_q, run_min_d;
    logic [NUM_CH-1:0][W-1:0] smp_max, smp_min;
    logic [NUM_CH-1:0][W:0]   smp_p2p;
    logic [NUM_CH*W-1:0]      out_max_q, out_max_d, out_min_q, out_min_d;
    logic [NUM_CH*(W+1)-1:0]  out_p2p_q, out_p2p_d;
    logic [CNT_W-1:0]         out_index_q, out_index_d;
    logic                     cfg_err_q, cfg_err_d;
    logic                     out_valid_q, out_valid_d;
    logic                     done_q, done_d;
    logic                     beat, close;

    // Candidate running extremes including the current beat; the first
    // sample of an interval seeds both.
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic signed [W-1:0] s, mx, mn;
        always_comb begin
            s  = bus.in_data[c*W +: W];
            mx = run_max_q[c];
            mn = run_min_q[c];
            if (sample_cnt_q == '0 || s > $signed(run_max_q[c])) mx = s;
            if (sample_cnt_q == '0 || s < $signed(run_min_q[c])) mn = s;
        end
        assign smp_max[c] = mx;
        assign smp_min[c] = mn;
        assign smp_p2p[c] = {mx[W-1], mx} - {mn[W-1], mn};
    end

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        num_d        = num_q;
        sample_cnt_d = sample_cnt_q;
        int_cnt_d    = int_cnt_q;
        run_max_d    = run_max_q;
        run_min_d    = run_min_q;
        out_max_d    = out_max_q;
        out_min_d    = out_min_q;
        out_p2p_d    = out_p2p_q;
        out_index_d  = out_index_q;
        cfg_err_d    = 1'b0;
        out_valid_d  = 1'b0;
        done_d       = 1'b0;
        int_nxt      = int_cnt_q + 1'b1;
        beat         = (state_q == RUN) && bus.in_valid;
        close        = beat && (sample_cnt_q == len_q - 1'b1);

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.interval_len == '0) begin
                        cfg_err_d = 1'b1;
                    end else begin
                        len_d        = bus.interval_len;
                        num_d        = bus.num_intervals;
                        sample_cnt_d = '0;
                        int_cnt_d    = '0;
                        state_d      = RUN;
                    end
                end
            end
            RUN: begin
                if (beat) begin
                    run_max_d    = smp_max;
                    run_min_d    = smp_min;
                    sample_cnt_d = sample_cnt_q + 1'b1;
                end
                if (close) begin
                    out_max_d    = smp_max;
                    out_min_d    = smp_min;
                    out_p2p_d    = smp_p2p;
                    out_index_d  = int_cnt_q;
                    out_valid_d  = 1'b1;
                    sample_cnt_d = '0;
                    int_cnt_d    = int_nxt;
                    if (num_q != '0 && int_nxt == num_q) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
                // A closing beat coincident with stop is still reported above.
                if (bus.stop) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            len_q        <= '0;
            num_q        <= '0;
            sample_cnt_q <= '0;
            int_cnt_q    <= '0;
            run_max_q    <= '0;
            run_min_q    <= '0;
            out_max_q    <= '0;
            out_min_q    <= '0;
            out_p2p_q    <= '0;
            out_index_q  <= '0;
            cfg_err_q    <= 1'b0;
            out_valid_q  <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            num_q        <= num_d;
            sample_cnt_q <= sample_cnt_d;
            int_cnt_q    <= int_cnt_d;
            run_max_q    <= run_max_d;
            run_min_q    <= run_min_d;
            out_max_q    <= out_max_d;
            out_min_q    <= out_min_d;
            out_p2p_q    <= out_p2p_d;
            out_index_q  <= out_index_d;
            cfg_err_q    <= cfg_err_d;
            out_valid_q  <= out_valid_d;
            done_q       <= done_d;
        end
    end

    assign bus.busy      = (state_q == RUN);
    assign bus.cfg_err   = cfg_err_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_index = out_index_q;
    assign bus.out_max   = out_max_q;
    assign bus.out_min   = out_min_q;
    assign bus.out_p2p   = out_p2p_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_audio_interval_peak_stream.sv
// Directed bench for audio_interval_peak_stream (2 channels, 4-bit interval
// counter so continuous-mode index wrap is reachable).
module tb_audio_interval_peak_stream;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    audio_interval_peak_stream_if #(.W(32), .NUM_CH(2), .LEN_W(16), .CNT_W(4)) bus ();

    audio_interval_peak_stream #(.W(32), .NUM_CH(2), .LEN_W(16), .CNT_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic pulse_start(input int len, input int num);
        bus.start = 1'b1; bus.interval_len = 16'(len); bus.num_intervals = 4'(num);
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic beat(input logic [31:0] a, input logic [31:0] b);
        bus.in_valid = 1'b1; bus.in_data = {b, a};
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic idle_cycle();
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        bus.start = 0; bus.stop = 0; bus.interval_len = 0; bus.num_intervals = 0;
        bus.in_valid = 0; bus.in_data = '0;
        #12;
        n_cmp++; if ({bus.busy, bus.cfg_err, bus.out_valid, bus.done} !== 4'b0) begin n_bad++; $display("FAIL reset_flags: got %b expected 0000", {bus.busy, bus.cfg_err, bus.out_valid, bus.done}); end
        n_cmp++; if ({bus.out_max, bus.out_min, bus.out_p2p, bus.out_index} !== '0) begin n_bad++; $display("FAIL reset_data: got nonzero expected 0"); end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_counted_run();
        int lo [10];
        int hi [10];
        int v;
        int pulses;
        lo = '{196608, 458752, 0, 327680, 458752, 262144, 196608, 458752, 327680, 327680};
        hi = '{-1245184, -1376256, -1441792, -1507328, -1310720, -1507328, -1441792, -1769472, -1376256, -1441792};
        pulses = 0;
        pulse_start(10, 10);
        n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL run_busy: got %b expected 1", bus.busy); end
        for (int i = 0; i < 100; i++) begin
            v = (i < 10) ? lo[i] : (i >= 90) ? hi[i-90] : 0;
            beat(32'(v), 32'd0);
            if (bus.out_valid) pulses++;
            n_cmp++; if (bus.out_valid !== (i % 10 == 9)) begin n_bad++; $display("FAIL run_valid beat %0d: got %b expected %b", i, bus.out_valid, (i % 10 == 9)); end
            n_cmp++; if (bus.done !== (i == 99)) begin n_bad++; $display("FAIL run_done beat %0d: got %b expected %b", i, bus.done, (i == 99)); end
            if (i % 10 == 9) begin
                n_cmp++; if (bus.out_index !== 4'(i / 10)) begin n_bad++; $display("FAIL run_index: got %0d expected %0d", bus.out_index, i / 10); end
            end
            if (i == 9) begin
                n_cmp++; if ($signed(bus.out_max[31:0]) !== 458752) begin n_bad++; $display("FAIL int0_max: got %0d expected 458752", $signed(bus.out_max[31:0])); end
                n_cmp++; if ($signed(bus.out_min[31:0]) !== 0) begin n_bad++; $display("FAIL int0_min: got %0d expected 0", $signed(bus.out_min[31:0])); end
                n_cmp++; if (bus.out_p2p[32:0] !== 33'd458752) begin n_bad++; $display("FAIL int0_p2p: got %0d expected 458752", bus.out_p2p[32:0]); end
            end
            if (i == 99) begin
                n_cmp++; if ($signed(bus.out_max[31:0]) !== -1245184) begin n_bad++; $display("FAIL int9_max: got %0d expected -1245184", $signed(bus.out_max[31:0])); end
                n_cmp++; if ($signed(bus.out_min[31:0]) !== -1769472) begin n_bad++; $display("FAIL int9_min: got %0d expected -1769472", $signed(bus.out_min[31:0])); end
                n_cmp++; if (bus.out_p2p[32:0] !== 33'd524288) begin n_bad++; $display("FAIL int9_p2p: got %0d expected 524288", bus.out_p2p[32:0]); end
                n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL run_busy_drop: got %b expected 0", bus.busy); end
            end
        end
        n_cmp++; if (pulses !== 10) begin n_bad++; $display("FAIL run_pulses: got %0d expected 10", pulses); end
        idle_cycle();
        n_cmp++; if ({bus.out_valid, bus.done} !== 2'b00) begin n_bad++; $display("FAIL run_after: got %b expected 00", {bus.out_valid, bus.done}); end
    endtask

    task automatic test_extremes();
        pulse_start(2, 1);
        beat(32'd5, 32'h7FFF_FFFF);
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL ext_early_valid: got %b expected 0", bus.out_valid); end
        beat(32'(-3), 32'h8000_0000);
        n_cmp++; if ({bus.out_valid, bus.done} !== 2'b11) begin n_bad++; $display("FAIL ext_valid_done: got %b expected 11", {bus.out_valid, bus.done}); end
        n_cmp++; if (bus.out_max[63:32] !== 32'h7FFF_FFFF) begin n_bad++; $display("FAIL ext_max1: got %h expected 7fffffff", bus.out_max[63:32]); end
        n_cmp++; if (bus.out_min[63:32] !== 32'h8000_0000) begin n_bad++; $display("FAIL ext_min1: got %h expected 80000000", bus.out_min[63:32]); end
        n_cmp++; if (bus.out_p2p[65:33] !== 33'h0_FFFF_FFFF) begin n_bad++; $display("FAIL ext_p2p1: got %h expected 0ffffffff", bus.out_p2p[65:33]); end
        n_cmp++; if ($signed(bus.out_min[31:0]) !== -3 || $signed(bus.out_max[31:0]) !== 5) begin n_bad++; $display("FAIL ext_ch0: got max %0d min %0d expected 5 -3", $signed(bus.out_max[31:0]), $signed(bus.out_min[31:0])); end
        n_cmp++; if (bus.out_p2p[32:0] !== 33'd8) begin n_bad++; $display("FAIL ext_p2p0: got %0d expected 8", bus.out_p2p[32:0]); end
        idle_cycle();
    endtask

    task automatic test_len1_gaps();
        logic [31:0] a [6];
        logic [31:0] b [6];
        int gaps [6];
        a = '{32'(-7), 32'd12, 32'd0, 32'h7FFF_FFFF, 32'(-1), 32'd300};
        b = '{32'd100, 32'(-100), 32'd5, 32'h8000_0000, 32'd0, 32'd1};
        gaps = '{0, 2, 1, 0, 3, 1};
        pulse_start(1, 6);
        for (int k = 0; k < 6; k++) begin
            for (int g = 0; g < gaps[k]; g++) begin
                idle_cycle();
                n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL gap_valid: got %b expected 0", bus.out_valid); end
            end
            beat(a[k], b[k]);
            n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_index !== 4'(k)) begin n_bad++; $display("FAIL len1_valid_idx: got %b/%0d expected 1/%0d", bus.out_valid, bus.out_index, k); end
            n_cmp++; if (bus.out_max !== {b[k], a[k]} || bus.out_min !== {b[k], a[k]}) begin n_bad++; $display("FAIL len1_maxmin: got %h/%h expected %h", bus.out_max, bus.out_min, {b[k], a[k]}); end
            n_cmp++; if (bus.out_p2p !== '0) begin n_bad++; $display("FAIL len1_p2p: got %h expected 0", bus.out_p2p); end
            n_cmp++; if (bus.done !== (k == 5)) begin n_bad++; $display("FAIL len1_done: got %b expected %b", bus.done, (k == 5)); end
        end
        idle_cycle();
    endtask

    task automatic test_continuous_stop();
        int pulses;
        int dones;
        int k;
        pulses = 0; dones = 0;
        pulse_start(3, 0);
        for (int i = 0; i < 51; i++) begin
            beat(32'(i), 32'(-i));
            if (bus.out_valid) pulses++;
            if (bus.done) dones++;
            n_cmp++; if (bus.out_valid !== (i % 3 == 2)) begin n_bad++; $display("FAIL cont_valid beat %0d: got %b expected %b", i, bus.out_valid, (i % 3 == 2)); end
            if (i % 3 == 2) begin
                k = i / 3;
                n_cmp++; if (bus.out_index !== 4'(k % 16)) begin n_bad++; $display("FAIL cont_index: got %0d expected %0d", bus.out_index, k % 16); end
                n_cmp++; if (bus.out_max !== {32'(-3*k), 32'(3*k+2)} || bus.out_min !== {32'(-3*k-2), 32'(3*k)}) begin n_bad++; $display("FAIL cont_maxmin k=%0d: got %h/%h", k, bus.out_max, bus.out_min); end
                n_cmp++; if (bus.out_p2p !== {33'd2, 33'd2}) begin n_bad++; $display("FAIL cont_p2p: got %h expected 2/2", bus.out_p2p); end
            end
        end
        n_cmp++; if (pulses !== 17 || dones !== 0) begin n_bad++; $display("FAIL cont_counts: got %0d pulses %0d done expected 17 0", pulses, dones); end
        n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL cont_busy: got %b expected 1", bus.busy); end
        beat(32'd51, 32'd0);
        beat(32'd52, 32'd0);
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL cont_partial_valid: got %b expected 0", bus.out_valid); end
        bus.stop = 1'b1;
        @(posedge clk); #1;
        bus.stop = 1'b0;
        n_cmp++; if ({bus.busy, bus.out_valid, bus.done} !== 3'b000) begin n_bad++; $display("FAIL stop_state: got %b expected 000", {bus.busy, bus.out_valid, bus.done}); end
        beat(32'd53, 32'd0);
        n_cmp++; if (bus.out_valid !== 1'b0 || bus.out_index !== 4'd0) begin n_bad++; $display("FAIL stop_hold: got %b/%0d expected 0/0", bus.out_valid, bus.out_index); end
    endtask

    task automatic test_cfg_err_and_restart();
        pulse_start(0, 1);
        n_cmp++; if ({bus.cfg_err, bus.busy} !== 2'b10) begin n_bad++; $display("FAIL cfg_err_pulse: got %b expected 10", {bus.cfg_err, bus.busy}); end
        idle_cycle();
        n_cmp++; if ({bus.cfg_err, bus.busy} !== 2'b00) begin n_bad++; $display("FAIL cfg_err_clear: got %b expected 00", {bus.cfg_err, bus.busy}); end
        pulse_start(2, 1);
        pulse_start(5, 3);
        n_cmp++; if ({bus.busy, bus.cfg_err} !== 2'b10) begin n_bad++; $display("FAIL restart_busy: got %b expected 10", {bus.busy, bus.cfg_err}); end
        beat(32'd1, 32'd1);
        beat(32'd4, 32'(-4));
        n_cmp++; if ({bus.out_valid, bus.done, bus.busy} !== 3'b110) begin n_bad++; $display("FAIL restart_done: got %b expected 110", {bus.out_valid, bus.done, bus.busy}); end
        n_cmp++; if (bus.out_max[31:0] !== 32'd4 || bus.out_min[31:0] !== 32'd1 || bus.out_p2p[32:0] !== 33'd3) begin n_bad++; $display("FAIL restart_vals: got %0d %0d %0d expected 4 1 3", bus.out_max[31:0], bus.out_min[31:0], bus.out_p2p[32:0]); end
        n_cmp++; if (bus.out_p2p[65:33] !== 33'd5) begin n_bad++; $display("FAIL restart_p2p1: got %0d expected 5", bus.out_p2p[65:33]); end
    endtask

    task automatic test_async_reset();
        pulse_start(4, 1);
        beat(32'd9, 32'd9);
        beat(32'd8, 32'd8);
        #3 reset = 1'b1;
        #1;
        n_cmp++; if ({bus.busy, bus.cfg_err, bus.out_valid, bus.done} !== 4'b0) begin n_bad++; $display("FAIL areset_flags: got %b expected 0000", {bus.busy, bus.cfg_err, bus.out_valid, bus.done}); end
        n_cmp++; if ({bus.out_max, bus.out_min, bus.out_p2p, bus.out_index} !== '0) begin n_bad++; $display("FAIL areset_data: got nonzero expected 0"); end
        #2 reset = 1'b0;
        @(posedge clk); #1;
        pulse_start(2, 2);
        beat(32'd10, 32'(-5));
        beat(32'd30, 32'(-40));
        n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_index !== 4'd0 || bus.done !== 1'b0) begin n_bad++; $display("FAIL post_int0: got v%b i%0d d%b expected v1 i0 d0", bus.out_valid, bus.out_index, bus.done); end
        n_cmp++; if (bus.out_max !== {32'(-5), 32'd30} || bus.out_min !== {32'(-40), 32'd10} || bus.out_p2p !== {33'd35, 33'd20}) begin n_bad++; $display("FAIL post_int0_vals: got %h %h %h", bus.out_max, bus.out_min, bus.out_p2p); end
        beat(32'(-1), 32'd7);
        beat(32'(-2), 32'd7);
        n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_index !== 4'd1 || bus.done !== 1'b1) begin n_bad++; $display("FAIL post_int1: got v%b i%0d d%b expected v1 i1 d1", bus.out_valid, bus.out_index, bus.done); end
        n_cmp++; if (bus.out_max !== {32'd7, 32'(-1)} || bus.out_min !== {32'd7, 32'(-2)} || bus.out_p2p !== {33'd0, 33'd1}) begin n_bad++; $display("FAIL post_int1_vals: got %h %h %h", bus.out_max, bus.out_min, bus.out_p2p); end
    endtask

    initial begin
        test_reset();
        test_counted_run();
        test_extremes();
        test_len1_gaps();
        test_continuous_stop();
        test_cfg_err_and_restart();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
